ssd1306_spi4_master: RTL and testbench



---
 rtl/ssd1306_pkg.sv | 46 ++++
 rtl/ssd1306_spi4_master_if.sv | 23 ++
 rtl/ssd1306_init_seq.sv | 27 ++
 rtl/ssd1306_spi4_master.sv | 185 ++++++++++++++++++
 tb/tb_ssd1306_spi4_master.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ssd1306_pkg.sv
// Shared SSD1306 command constants, FSM state encoding and the power-on command ROM
// used by the SPI4 master and its optional init sequencer.
package ssd1306_pkg;

    localparam logic [7:0] CMD_ENTIRE_ON_RESUME = 8'hA4;
    localparam logic [7:0] CMD_ENTIRE_ON_FORCE  = 8'hA5;
    localparam logic [7:0] CMD_NORMAL_DISPLAY   = 8'hA6;
    localparam logic [7:0] CMD_INVERT_DISPLAY   = 8'hA7;
    localparam logic [7:0] CMD_DISPLAY_OFF      = 8'hAE;
    localparam logic [7:0] CMD_DISPLAY_ON       = 8'hAF;
    localparam logic [7:0] CMD_SEG_REMAP_0      = 8'hA0;
    localparam logic [7:0] CMD_SEG_REMAP_127    = 8'hA1;
    localparam logic [7:0] CMD_COM_SCAN_INC     = 8'hC0;
    localparam logic [7:0] CMD_COM_SCAN_DEC     = 8'hC8;
    localparam logic [7:0] CMD_MEM_ADDR_MODE    = 8'h20;
    localparam logic [7:0] CMD_PAGE_START_BASE  = 8'hB0;

    localparam logic [7:0] ADDR_MODE_HORIZONTAL = 8'h00;
    localparam logic [7:0] ADDR_MODE_VERTICAL   = 8'h01;
    localparam logic [7:0] ADDR_MODE_PAGE       = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        HOLD,
        GAP,
        INIT
    } state_t;

    localparam int INIT_LEN = 9;

    // Element 0 is the first byte sent (packed concatenation lists the last byte first).
    localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
        CMD_DISPLAY_ON,
        CMD_PAGE_START_BASE,
        CMD_ENTIRE_ON_RESUME,
        CMD_NORMAL_DISPLAY,
        CMD_COM_SCAN_DEC,
        CMD_SEG_REMAP_127,
        ADDR_MODE_HORIZONTAL,
        CMD_MEM_ADDR_MODE,
        CMD_DISPLAY_OFF
    };

endpackage

// File: rtl/ssd1306_spi4_master_if.sv
// Byte stream handshake between a command/frame generator and the SSD1306 SPI4 master.
interface ssd1306_spi4_master_if;

    logic       in_valid_i;
    logic       in_ready_o;
    logic [7:0] in_data_i;
    logic       in_dc_i;

    modport master (
        output in_valid_i,
        output in_data_i,
        output in_dc_i,
        input  in_ready_o
    );

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  in_dc_i,
        output in_ready_o
    );

endinterface

// File: rtl/ssd1306_init_seq.sv
// Walks the power-on command ROM and offers each byte on a valid/ready handshake.
module ssd1306_init_seq
    import ssd1306_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       seq_ready,
    output logic       seq_valid,
    output logic [7:0] seq_data
);

    localparam int IW = $clog2(INIT_LEN + 1);

    logic [IW-1:0] idx_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_reg <= '0;
        end else if (seq_valid && seq_ready) begin
            idx_reg <= idx_reg + IW'(1);
        end
    end

    assign seq_valid = (idx_reg != IW'(INIT_LEN));
    assign seq_data  = seq_valid ? INIT_ROM[idx_reg] : 8'h00;

endmodule

// File: rtl/ssd1306_spi4_master.sv
// SPI mode-0, MSB-first, write-only byte serializer for an SSD1306 (cs/sck/sdo/dc).
// Define SSD1306_INIT_SEQ_EN to send the power-on command sequence automatically after reset.
module ssd1306_spi4_master
    import ssd1306_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    ssd1306_spi4_master_if.slave         bus,
    output logic                         busy_o,
    output logic                         init_done_o,
    output logic                         cs_on,
    output logic                         sck_o,
    output logic                         sdo_o,
    output logic                         dc_o
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV - 1);
    // A byte started from IDLE gets one extra low cycle so sdo settles before the first rise.
    localparam logic [CW-1:0] FIRST_LOAD = CW'(CLK_DIV);

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    bit_reg;
    logic [7:0]    shift_reg;
    logic          cs_reg;
    logic          sck_reg;
    logic          sdo_reg;
    logic          dc_reg;
    logic          busy_reg;
    logic          ready_reg;

    logic          src_valid;
    logic [7:0]    src_data;
    logic          src_dc;
    logic          accept;
    logic          init_done;

`ifdef SSD1306_INIT_SEQ_EN
    localparam state_t RESET_STATE = INIT;

    logic       init_done_reg;
    logic       seq_valid;
    logic       seq_ready;
    logic [7:0] seq_data;

    ssd1306_init_seq u_init_seq (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .seq_ready (seq_ready),
        .seq_valid (seq_valid),
        .seq_data  (seq_data)
    );

    // The ROM owns the input mux until the whole sequence has left through GAP.
    assign seq_ready = !init_done_reg && ready_reg;
    assign src_valid = init_done_reg ? bus.in_valid_i : seq_valid;
    assign src_data  = init_done_reg ? bus.in_data_i  : seq_data;
    assign src_dc    = init_done_reg ? bus.in_dc_i    : 1'b0;
    assign init_done = init_done_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            init_done_reg <= 1'b0;
        end else if (state_reg == GAP && cnt_reg == '0) begin
            init_done_reg <= 1'b1;
        end
    end
`else
    localparam state_t RESET_STATE = IDLE;

    assign src_valid = bus.in_valid_i;
    assign src_data  = bus.in_data_i;
    assign src_dc    = bus.in_dc_i;
    assign init_done = 1'b1;
`endif

    assign accept         = src_valid && ready_reg;
    assign bus.in_ready_o = ready_reg && init_done;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= RESET_STATE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            cs_reg    <= 1'b1;
            sck_reg   <= 1'b0;
            sdo_reg   <= 1'b0;
            dc_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b1;
        end else begin
            case (state_reg)
                IDLE, INIT: begin
                    busy_reg <= (state_reg == INIT) || accept;
                    if (accept) begin
                        state_reg <= LO;
                        cnt_reg   <= FIRST_LOAD;
                        bit_reg   <= '0;
                        shift_reg <= src_data;
                        sdo_reg   <= src_data[7];
                        dc_reg    <= src_dc;
                        cs_reg    <= 1'b0;
                        ready_reg <= 1'b0;
                    end
                end
                LO: begin
                    if (cnt_reg == '0) begin
                        state_reg <= HI;
                        cnt_reg   <= HALF_LOAD;
                        sck_reg   <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                HI: begin
                    if (cnt_reg == '0) begin
                        cnt_reg <= HALF_LOAD;
                        sck_reg <= 1'b0;
                        bit_reg <= bit_reg + 3'd1;
                        if (bit_reg == 3'd7) begin
                            state_reg <= HOLD;
                            ready_reg <= (CLK_DIV == 1);
                        end else begin
                            state_reg <= LO;
                            shift_reg <= {shift_reg[6:0], 1'b0};
                            sdo_reg   <= shift_reg[6];
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt_reg == '0) begin
                        cnt_reg   <= HALF_LOAD;
                        ready_reg <= 1'b0;
                        if (accept) begin
                            // Back-to-back byte: chip select stays low across the boundary.
                            state_reg <= LO;
                            bit_reg   <= '0;
                            shift_reg <= src_data;
                            sdo_reg   <= src_data[7];
                            dc_reg    <= src_dc;
                        end else begin
                            state_reg <= GAP;
                            cs_reg    <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                        if (cnt_reg == CW'(1)) begin
                            ready_reg <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (cnt_reg == '0) begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cs_reg    <= 1'b1;
                    sck_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign busy_o      = busy_reg;
    assign init_done_o = init_done;
    assign cs_on       = cs_reg;
    assign sck_o       = sck_reg;
    assign sdo_o       = sdo_reg;
    assign dc_o        = dc_reg;

endmodule

// File: tb/tb_ssd1306_spi4_master.sv
// Scoreboard bench for ssd1306_spi4_master: two instances (CLK_DIV=2 and CLK_DIV=1),
// bytes rebuilt from the pins are compared against the queue of issued bytes.
module tb_ssd1306_spi4_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic rst0 = 1'b1;
    logic rst1 = 1'b1;

    ssd1306_spi4_master_if b0();
    ssd1306_spi4_master_if b1();

    logic busy0, done0, cs0, sck0, sdo0, dc0;
    logic busy1, done1, cs1, sck1, sdo1, dc1;

    ssd1306_spi4_master #(.CLK_DIV(2)) dut0 (
        .clk_i(clk), .rst_i(rst0), .bus(b0), .busy_o(busy0), .init_done_o(done0),
        .cs_on(cs0), .sck_o(sck0), .sdo_o(sdo0), .dc_o(dc0)
    );

    ssd1306_spi4_master #(.CLK_DIV(1)) dut1 (
        .clk_i(clk), .rst_i(rst1), .bus(b1), .busy_o(busy1), .init_done_o(done1),
        .cs_on(cs1), .sck_o(sck1), .sdo_o(sdo1), .dc_o(dc1)
    );

    wire [1:0] rst_w  = {rst1, rst0};
    wire [1:0] cs_w   = {cs1, cs0};
    wire [1:0] sck_w  = {sck1, sck0};
    wire [1:0] sdo_w  = {sdo1, sdo0};
    wire [1:0] dc_w   = {dc1, dc0};
    wire [1:0] busy_w = {busy1, busy0};
    wire [1:0] done_w = {done1, done0};
    wire [1:0] rdy_w  = {b1.in_ready_o, b0.in_ready_o};

    logic [8:0] exp_q0[$];
    logic [8:0] exp_q1[$];

`ifdef SSD1306_INIT_SEQ_EN
    localparam bit EXP_RST_READY = 1'b0;
    localparam bit EXP_RST_DONE  = 1'b0;
    logic [7:0] init_bytes [9] = '{8'hAE, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hA6, 8'hA4, 8'hB0, 8'hAF};
`else
    localparam bit EXP_RST_READY = 1'b1;
    localparam bit EXP_RST_DONE  = 1'b1;
`endif

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic drive(input int u, input logic v, input logic [7:0] d, input logic c);
        if (u == 0) begin
            b0.in_valid_i = v; b0.in_data_i = d; b0.in_dc_i = c;
        end else begin
            b1.in_valid_i = v; b1.in_data_i = d; b1.in_dc_i = c;
        end
    endtask

    task automatic frame_done(input int u, input logic [8:0] got);
        logic [8:0] e;
        if ((u == 0 && exp_q0.size() == 0) || (u == 1 && exp_q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte_u%0d: got %0h, expected none", u, got);
        end else begin
            e = (u == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("byte_u%0d", u), int'(got), int'(e));
        end
    endtask

    // Monitor: rebuild bytes on SCK rises, compare {dc,byte} on the 8th falling edge.
    int         nb [2]        = '{0, 0};
    logic [7:0] sh [2];
    logic       psck [2]      = '{1'b0, 1'b0};
    logic       pcs [2]       = '{1'b1, 1'b1};
    logic       psdo [2]      = '{1'b0, 1'b0};
    int         cs_rises [2]  = '{0, 0};

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst_w[u]) begin
                nb[u] = 0;
            end else begin
                if (!cs_w[u] && sck_w[u] && !psck[u]) begin
                    sh[u] = {sh[u][6:0], sdo_w[u]};
                    nb[u] = nb[u] + 1;
                end
                if (sck_w[u] && psck[u])
                    check($sformatf("sdo_stable_hi_u%0d", u), int'(sdo_w[u]), int'(psdo[u]));
                if (!cs_w[u] && !sck_w[u] && psck[u] && nb[u] == 8) begin
                    frame_done(u, {dc_w[u], sh[u]});
                    nb[u] = 0;
                end
                if (cs_w[u] && !pcs[u])
                    cs_rises[u] = cs_rises[u] + 1;
            end
            psck[u] = sck_w[u];
            pcs[u]  = cs_w[u];
            psdo[u] = sdo_w[u];
        end
    end

    // Offer a byte (called at a negedge); returns the cycle count just before the accepting edge.
    task automatic send(input int u, input logic [7:0] d, input logic c, output int hs);
        int n;
        n = 0;
        drive(u, 1'b1, d, c);
        if (u == 0) exp_q0.push_back({c, d}); else exp_q1.push_back({c, d});
        while (!rdy_w[u] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout_u%0d: got no ready, expected ready for %0h", u, d);
        end
        hs = cyc;
        @(negedge clk);
        drive(u, 1'b0, d, c);
    endtask

    // Starting at the negedge after an accept (k=0), measure the frame until busy drops.
    task automatic wait_frame(input int u, output int first_rise, output int cs_low,
                              output int total, output int tog);
        logic last_sdo;
        last_sdo   = sdo_w[u];
        first_rise = -1;
        cs_low     = 0;
        total      = -1;
        tog        = 0;
        for (int k = 0; k < 400; k++) begin
            if (!cs_w[u]) begin
                cs_low++;
                if (sdo_w[u] != last_sdo) tog++;
            end
            last_sdo = sdo_w[u];
            if (sck_w[u] && first_rise < 0) first_rise = k;
            if (!busy_w[u]) begin
                total = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic reset_unit(input int u);
`ifdef SSD1306_INIT_SEQ_EN
        int n;
        int bad;
        int rises0;
`endif
        if (u == 0) rst0 = 1'b1; else rst1 = 1'b1;
        drive(u, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check($sformatf("rst_cs_u%0d", u), int'(cs_w[u]), 1);
        check($sformatf("rst_sck_u%0d", u), int'(sck_w[u]), 0);
        check($sformatf("rst_sdo_u%0d", u), int'(sdo_w[u]), 0);
        check($sformatf("rst_dc_u%0d", u), int'(dc_w[u]), 0);
        check($sformatf("rst_busy_u%0d", u), int'(busy_w[u]), 0);
        check($sformatf("rst_ready_u%0d", u), int'(rdy_w[u]), int'(EXP_RST_READY));
        check($sformatf("rst_init_done_u%0d", u), int'(done_w[u]), int'(EXP_RST_DONE));
        @(negedge clk);
`ifdef SSD1306_INIT_SEQ_EN
        for (int i = 0; i < 9; i++) begin
            if (u == 0) exp_q0.push_back({1'b0, init_bytes[i]});
            else        exp_q1.push_back({1'b0, init_bytes[i]});
        end
        rises0 = cs_rises[u];
`endif
        if (u == 0) rst0 = 1'b0; else rst1 = 1'b0;
`ifdef SSD1306_INIT_SEQ_EN
        n   = 0;
        bad = 0;
        while (!done_w[u] && n < 1000) begin
            @(negedge clk);
            n++;
            if (rdy_w[u] && !done_w[u]) bad++;
        end
        check($sformatf("init_finished_u%0d", u), int'(n < 1000), 1);
        check($sformatf("init_ready_low_u%0d", u), bad, 0);
        check($sformatf("init_done_after_gap_u%0d", u), int'(busy_w[u]), 0);
        check($sformatf("init_single_burst_u%0d", u), cs_rises[u] - rises0, 1);
        check($sformatf("init_bytes_seen_u%0d", u), (u == 0) ? exp_q0.size() : exp_q1.size(), 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected $finish before 200000 ns");
        $fatal(1);
    end

    initial begin
        int hs [4];
        int fr, csl, tot, tog, r0, n;

        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        reset_unit(0);
        reset_unit(1);

        // Isolated command byte A5 at CLK_DIV=2.
        send(0, 8'hA5, 1'b0, hs[0]);
        wait_frame(0, fr, csl, tot, tog);
        check("t1_first_rise", fr, 3);
        check("t1_cs_low", csl, 35);
        check("t1_to_idle", tot, 37);

        // Burst with valid held: A1, 20, 00 as commands, FF as data.
        r0 = cs_rises[0];
        send(0, 8'hA1, 1'b0, hs[0]);
        send(0, 8'h20, 1'b0, hs[1]);
        send(0, 8'h00, 1'b0, hs[2]);
        send(0, 8'hFF, 1'b1, hs[3]);
        check("t2_dc_after_4th_load", int'(dc_w[0]), 1);
        wait_frame(0, fr, csl, tot, tog);
        check("t2_hs_gap_1_2", hs[1] - hs[0], 35);
        check("t2_hs_gap_2_3", hs[2] - hs[1], 34);
        check("t2_hs_gap_3_4", hs[3] - hs[2], 34);
        check("t2_last_first_rise", fr, 2);
        check("t2_last_to_idle", tot, 36);
        check("t2_one_cs_rise", cs_rises[0] - r0, 1);

        // Back-pressure: a decoy value is offered mid-frame, then replaced before acceptance.
        send(0, 8'hC3, 1'b1, hs[0]);
        drive(0, 1'b1, 8'h11, 1'b0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rdy_w[0]) n++;
        end
        check("t3_no_early_ready", n, 0);
        send(0, 8'h96, 1'b1, hs[1]);
        check("t3_accept_at_hold_end", hs[1] - hs[0], 35);
        wait_frame(0, fr, csl, tot, tog);
        check("t3_to_idle", tot, 36);

        // Reset after 4 SCK rises of 3C: the partial byte is dropped, 81 follows intact.
        send(0, 8'h3C, 1'b0, hs[0]);
        n = 0;
        while (nb[0] < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t4_four_rises", nb[0], 4);
        void'(exp_q0.pop_back());
        reset_unit(0);
        send(0, 8'h81, 1'b0, hs[0]);
        wait_frame(0, fr, csl, tot, tog);
        check("t4_next_cs_low", csl, 35);
        check("t4_next_to_idle", tot, 37);

        // CLK_DIV=1: data byte 55.
        send(1, 8'h55, 1'b1, hs[0]);
        wait_frame(1, fr, csl, tot, tog);
        check("t5_first_rise", fr, 2);
        check("t5_cs_low", csl, 18);
        check("t5_to_idle", tot, 19);
        check("t5_sdo_toggles", tog, 7);

        repeat (4) @(negedge clk);
        check("q0_drained", exp_q0.size(), 0);
        check("q1_drained", exp_q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
